fdiv_ctrl: RTL and testbench

FDIV_CTRL -- requirements
Module: fdiv_ctrl

---
 rtl/fdiv_ctrl_if.sv | 28 ++
 rtl/fdiv_ctrl.sv | 128 ++++++++++++
 tb/tb_fdiv_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_ctrl_if.sv
// Request/response bundle between issue, the FDIV sequencer and writeback.
// Handshakes are strict valid/ready: a transfer happens on a clock edge where valid and ready are both high.
interface fdiv_ctrl_if #(
    parameter int TAGW = 5,
    parameter int DW   = 33
);
    logic            req_valid;
    logic [TAGW-1:0] req_tag;
    logic            req_ready;
    logic            flush;
    logic            dp_issue;
    logic [DW-1:0]   dp_res;
    logic            resp_valid;
    logic [TAGW-1:0] resp_tag;
    logic [DW-1:0]   resp_data;
    logic            resp_ready;
    logic            busy;

    modport slave (
        input  req_valid, req_tag, flush, dp_res, resp_ready,
        output req_ready, dp_issue, resp_valid, resp_tag, resp_data, busy
    );

    modport master (
        output req_valid, req_tag, flush, dp_res, resp_ready,
        input  req_ready, dp_issue, resp_valid, resp_tag, resp_data, busy
    );
endinterface

// File: rtl/fdiv_ctrl.sv
// Sequencer for a fixed-latency FP divider: tracks in-flight tags in a shift register
// and buffers {tag, result} in a credit-protected in-order FIFO.
module fdiv_ctrl #(
    parameter int LAT   = 28,
    parameter int DEPTH = 4,
    parameter int TAGW  = 5,
    parameter int DW    = 33
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_ctrl_if.slave  io
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = TAGW + DW;

    logic [LAT-1:0]  stg_vld_q, stg_vld_d;
    logic [TAGW-1:0] stg_tag_q [LAT];
    logic [TAGW-1:0] stg_tag_d [LAT];
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   inflight_cnt_q, inflight_cnt_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic            accept;
    logic            complete;
    logic            push;
    logic            pop;
    logic            resp_valid;
    logic [CW:0]     credit_used;
    logic            req_ready;

    // Credits are taken from registered counts, so a pop frees its slot one cycle later.
    always_comb begin
        credit_used = {1'b0, inflight_cnt_q} + {1'b0, fifo_cnt_q};
        req_ready   = !rst && !io.flush && (credit_used < (CW+1)'(DEPTH));
        accept      = io.req_valid && req_ready;
        complete    = stg_vld_q[LAT-1];
        push        = complete && !io.flush;
        resp_valid  = (fifo_cnt_q != '0);
        pop         = resp_valid && io.resp_ready && !io.flush;
    end

    always_comb begin
        stg_vld_d    = {stg_vld_q[LAT-2:0], accept};
        stg_tag_d[0] = io.req_tag;
        for (int i = 1; i < LAT; i++) begin
            stg_tag_d[i] = stg_tag_q[i-1];
        end
        if (io.flush) begin
            stg_vld_d = '0;
        end
    end

    always_comb begin
        inflight_cnt_d = inflight_cnt_q;
        if (accept && !complete) begin
            inflight_cnt_d = inflight_cnt_q + CW'(1);
        end else if (!accept && complete) begin
            inflight_cnt_d = inflight_cnt_q - CW'(1);
        end
        if (io.flush) begin
            inflight_cnt_d = '0;
        end
    end

    // Pointer wrap is free because DEPTH is a power of two; fullness comes from the count.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {stg_tag_q[LAT-1], io.dp_res};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
        if (io.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_cnt_q <= '0;
            fifo_cnt_q     <= '0;
        end else begin
            stg_vld_q      <= stg_vld_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_cnt_q <= inflight_cnt_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    // Payload storage is qualified by the valid bits and counts, so it needs no reset.
    always_ff @(posedge clk) begin
        stg_tag_q <= stg_tag_d;
        mem_q     <= mem_d;
    end

    logic [EW-1:0] head;

    always_comb begin
        head = resp_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign io.req_ready  = req_ready;
    assign io.dp_issue   = accept;
    assign io.resp_valid = resp_valid;
    assign io.resp_tag   = head[EW-1:DW];
    assign io.resp_data  = head[DW-1:0];
    assign io.busy       = (inflight_cnt_q != '0) || (fifo_cnt_q != '0);
endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl (LAT=4, DEPTH=4) with a fixed-latency datapath model
// and an in-order expected queue for the streaming phase.
module tb_fdiv_ctrl;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TAGW  = 5;
    localparam int DW    = 33;
    localparam int EW    = TAGW + DW;

    logic clk;
    logic rst;
    logic [DW-1:0] req_data;
    logic [DW-1:0] dp_pipe [LAT];

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] ent;
    logic [EW-1:0] prev_head;
    logic          hold_prev;
    logic          exp_ready;
    int            out_cnt;
    int            guard;

    fdiv_ctrl_if #(.TAGW(TAGW), .DW(DW)) io ();

    fdiv_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: the operand launched with dp_issue comes back LAT edges later.
    always @(posedge clk) begin
        dp_pipe[0] <= io.dp_issue ? req_data : '0;
        for (int i = 1; i < LAT; i++) begin
            dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign io.dp_res = dp_pipe[LAT-1];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] data_of(input logic [TAGW-1:0] t);
        return {t, 28'h5A51234};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_expect(input logic [TAGW-1:0] t, input logic [DW-1:0] d);
        int n;
        n = 0;
        while (!io.resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("pop_valid", 64'(io.resp_valid), 64'd1);
        chk("pop_tag", 64'(io.resp_tag), 64'(t));
        chk("pop_data", 64'(io.resp_data), 64'(d));
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        io.req_valid  = 1'b0;
        io.req_tag    = '0;
        io.flush      = 1'b0;
        io.resp_ready = 1'b0;
        req_data      = '0;
        #2;
        chk("rst_req_ready", 64'(io.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(io.resp_valid), 64'd0);
        chk("rst_busy", 64'(io.busy), 64'd0);
        chk("rst_resp_tag", 64'(io.resp_tag), 64'd0);
        chk("rst_resp_data", 64'(io.resp_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel_req_ready", 64'(io.req_ready), 64'd1);

        // Single op: tag 5, result {0, 0x7F, 0x400000}
        io.req_valid = 1'b1;
        io.req_tag   = 5'd5;
        req_data     = {1'b0, 9'h07F, 23'h400000};
        #1;
        chk("single_issue", 64'(io.dp_issue), 64'd1);
        tick();
        io.req_valid = 1'b0;
        #1;
        chk("single_busy", 64'(io.busy), 64'd1);
        chk("single_no_issue", 64'(io.dp_issue), 64'd0);
        for (int k = 1; k < LAT; k++) begin
            tick();
            chk("single_early", 64'(io.resp_valid), 64'd0);
        end
        tick();
        chk("single_valid", 64'(io.resp_valid), 64'd1);
        chk("single_tag", 64'(io.resp_tag), 64'd5);
        chk("single_data", 64'(io.resp_data), 64'h0_3FC0_0000);
        io.resp_ready = 1'b1;
        tick();
        io.resp_ready = 1'b0;
        #1;
        chk("single_popped", 64'(io.resp_valid), 64'd0);
        chk("single_idle", 64'(io.busy), 64'd0);

        // Back-to-back tags 1..4 with writeback stalled
        for (int i = 1; i <= 4; i++) begin
            io.req_valid = 1'b1;
            io.req_tag   = TAGW'(i);
            req_data     = data_of(TAGW'(i));
            #1;
            chk("b2b_ready", 64'(io.req_ready), 64'd1);
            chk("b2b_issue", 64'(io.dp_issue), 64'd1);
            tick();
        end
        io.req_tag = 5'd5;
        req_data   = data_of(5'd5);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("b2b_full_ready", 64'(io.req_ready), 64'd0);
            chk("b2b_no_fifth", 64'(io.dp_issue), 64'd0);
            tick();
        end
        io.req_valid = 1'b0;
        #1;
        chk("b2b_head_valid", 64'(io.resp_valid), 64'd1);
        chk("b2b_head_tag", 64'(io.resp_tag), 64'd1);
        chk("b2b_busy", 64'(io.busy), 64'd1);

        // Release one slot; the freed credit appears one cycle later
        io.req_valid  = 1'b1;
        io.req_tag    = 5'd6;
        req_data      = data_of(5'd6);
        io.resp_ready = 1'b1;
        #1;
        chk("rel_same_ready", 64'(io.req_ready), 64'd0);
        chk("rel_same_issue", 64'(io.dp_issue), 64'd0);
        chk("rel_pop_tag", 64'(io.resp_tag), 64'd1);
        chk("rel_pop_data", 64'(io.resp_data), 64'(data_of(5'd1)));
        tick();
        io.resp_ready = 1'b0;
        #1;
        chk("rel_next_ready", 64'(io.req_ready), 64'd1);
        chk("rel_next_issue", 64'(io.dp_issue), 64'd1);
        chk("rel_hold_tag", 64'(io.resp_tag), 64'd2);
        tick();
        io.req_valid  = 1'b0;
        io.resp_ready = 1'b1;
        pop_expect(5'd2, data_of(5'd2));
        pop_expect(5'd3, data_of(5'd3));
        pop_expect(5'd4, data_of(5'd4));
        pop_expect(5'd6, data_of(5'd6));
        chk("rel_drained_valid", 64'(io.resp_valid), 64'd0);
        chk("rel_drained_busy", 64'(io.busy), 64'd0);
        io.resp_ready = 1'b0;

        // Flush with tags 7 and 8 in flight
        io.req_valid = 1'b1;
        io.req_tag   = 5'd7;
        req_data     = data_of(5'd7);
        tick();
        io.req_tag = 5'd8;
        req_data   = data_of(5'd8);
        tick();
        io.flush   = 1'b1;
        io.req_tag = 5'd9;
        req_data   = data_of(5'd9);
        #1;
        chk("flush_ready", 64'(io.req_ready), 64'd0);
        chk("flush_issue", 64'(io.dp_issue), 64'd0);
        tick();
        io.flush     = 1'b0;
        io.req_valid = 1'b0;
        io.resp_ready = 1'b1;
        #1;
        chk("flush_busy", 64'(io.busy), 64'd0);
        chk("flush_req_ready", 64'(io.req_ready), 64'd1);
        chk("flush_resp_valid", 64'(io.resp_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("flush_no_resp", 64'(io.resp_valid), 64'd0);
        end

        // Flush in the very cycle the last stage completes
        io.req_valid = 1'b1;
        io.req_tag   = 5'd10;
        req_data     = data_of(5'd10);
        tick();
        io.req_valid = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        io.flush = 1'b1;
        tick();
        io.flush = 1'b0;
        #1;
        chk("flush_last_valid", 64'(io.resp_valid), 64'd0);
        chk("flush_last_busy", 64'(io.busy), 64'd0);
        io.resp_ready = 1'b0;

        // Reset with one buffered and two in flight
        io.req_valid = 1'b1;
        io.req_tag   = 5'd11;
        req_data     = data_of(5'd11);
        tick();
        io.req_valid = 1'b0;
        tick();
        tick();
        io.req_valid = 1'b1;
        io.req_tag   = 5'd12;
        req_data     = data_of(5'd12);
        tick();
        io.req_tag = 5'd13;
        req_data   = data_of(5'd13);
        tick();
        io.req_valid = 1'b0;
        #1;
        chk("mid_buffered", 64'(io.resp_valid), 64'd1);
        chk("mid_buffered_tag", 64'(io.resp_tag), 64'd11);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(io.resp_valid), 64'd0);
        chk("mid_rst_busy", 64'(io.busy), 64'd0);
        chk("mid_rst_ready", 64'(io.req_ready), 64'd0);
        chk("mid_rst_tag", 64'(io.resp_tag), 64'd0);
        tick();
        tick();
        rst           = 1'b0;
        io.resp_ready = 1'b1;
        #1;
        chk("mid_rel_ready", 64'(io.req_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mid_no_stale", 64'(io.resp_valid), 64'd0);
        end
        chk("mid_idle", 64'(io.busy), 64'd0);

        // Streaming: 50% requests, 70% writeback acceptance
        out_cnt   = 0;
        hold_prev = 1'b0;
        prev_head = '0;
        for (int c = 0; c < 10000; c++) begin
            io.req_valid  = 1'($urandom_range(0, 1));
            io.req_tag    = TAGW'($urandom);
            req_data      = DW'({$urandom, $urandom});
            io.resp_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_ready = (out_cnt < DEPTH);
            chk("s_ready", 64'(io.req_ready), 64'(exp_ready));
            chk("s_issue", 64'(io.dp_issue), 64'(io.req_valid && exp_ready));
            if (hold_prev) begin
                chk("s_hold_valid", 64'(io.resp_valid), 64'd1);
                chk("s_hold_head", 64'({io.resp_tag, io.resp_data}), 64'(prev_head));
            end
            if (io.resp_valid && io.resp_ready) begin
                chk("s_not_extra", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    ent = exp_q.pop_front();
                    chk("s_order", 64'({io.resp_tag, io.resp_data}), 64'(ent));
                end
                out_cnt--;
            end
            if (io.req_valid && exp_ready) begin
                exp_q.push_back({io.req_tag, req_data});
                out_cnt++;
            end
            hold_prev = io.resp_valid && !io.resp_ready;
            prev_head = {io.resp_tag, io.resp_data};
            tick();
        end
        io.req_valid  = 1'b0;
        io.resp_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2 * DEPTH) begin
            ent = exp_q.pop_front();
            pop_expect(ent[EW-1:DW], ent[DW-1:0]);
            guard++;
        end
        chk("s_all_returned", 64'(exp_q.size()), 64'd0);
        #1;
        chk("s_final_busy", 64'(io.busy), 64'd0);
        chk("s_final_valid", 64'(io.resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
